// File: rtl/ctrl_seq_fsm.sv
// Control sequencer for the sample rate converter: walks the allocation list per sample.
// Optional busy-cycle counter on cyc_cnt is enabled by defining SRC_SEQ_PERF_CNT_EN.
module ctrl_seq_fsm #(
  parameter int TAPS_W    = 6,
  parameter int ALLOC_W   = 3,
  parameter int ALLOC_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              in_valid,
  output logic              in_ack,
  input  logic              out_ready,
  output logic              out_valid,
  input  logic [TAPS_W-1:0] tap_len,
  input  logic              alloc_last,
  input  logic              err_req,
  output logic [2:0]        fsm_state,
  output logic              ctrl_en,
  output logic              busy,
  output logic              seq_err,
  output logic [15:0]       cyc_cnt,
  output logic [3:0]        dbg_state
);

  // Low three bits of S1..S8 equal the decoder code; bit 3 marks the idle pair.
  localparam logic [3:0] ST_S1      = 4'b0000;
  localparam logic [3:0] ST_S2      = 4'b0001;
  localparam logic [3:0] ST_S3      = 4'b0010;
  localparam logic [3:0] ST_S4      = 4'b0011;
  localparam logic [3:0] ST_S5      = 4'b0100;
  localparam logic [3:0] ST_S6      = 4'b0101;
  localparam logic [3:0] ST_S7      = 4'b0110;
  localparam logic [3:0] ST_S8      = 4'b0111;
  localparam logic [3:0] ST_IDLE    = 4'b1000;
  localparam logic [3:0] ST_WAIT_IN = 4'b1001;

  logic [3:0]         state_q, state_d;
  logic [TAPS_W-1:0]  tap_len_q, tap_cnt_q;
  logic [ALLOC_W-1:0] alloc_idx_q;
  logic               alloc_last_q, err_req_q, stop_pend_q, ctrl_en_q;
  logic               idx_at_max, is_last;

  assign idx_at_max = (alloc_idx_q == ALLOC_W'(ALLOC_MAX - 1));
  assign is_last    = alloc_last_q || idx_at_max;
  assign dbg_state  = state_q;

  // Output handshake: a sample transfers on any cycle where out_valid and out_ready
  // are both high; out_valid stays up until then and ctrl_en marks that transfer cycle.
  assign ctrl_en = ctrl_en_q | (out_valid & out_ready);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start && !stop) state_d = ST_WAIT_IN;
      ST_WAIT_IN: begin
        if (stop || stop_pend_q) state_d = ST_IDLE;
        else if (in_valid)       state_d = ST_S7;
      end
      ST_S7:      state_d = ST_S1;
      ST_S1:      state_d = ST_S2;
      ST_S2:      state_d = (tap_len_q == '0) ? ST_S4 : ST_S3;
      ST_S3:      if (tap_cnt_q == TAPS_W'(1)) state_d = ST_S4;
      ST_S4: begin
        if (err_req_q)    state_d = ST_S5;
        else if (is_last) state_d = ST_S6;
        else              state_d = ST_S8;
      end
      ST_S5:      state_d = is_last ? ST_S6 : ST_S8;
      ST_S8:      state_d = ST_S1;
      ST_S6:      if (out_ready) state_d = ST_WAIT_IN;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      fsm_state    <= 3'b000;
      busy         <= 1'b0;
      ctrl_en_q    <= 1'b0;
      out_valid    <= 1'b0;
      in_ack       <= 1'b0;
      seq_err      <= 1'b0;
      stop_pend_q  <= 1'b0;
      tap_len_q    <= '0;
      tap_cnt_q    <= '0;
      alloc_idx_q  <= '0;
      alloc_last_q <= 1'b0;
      err_req_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      fsm_state   <= state_d[3] ? 3'b000 : state_d[2:0];
      busy        <= (state_d != ST_IDLE);
      ctrl_en_q   <= !state_d[3] && (state_d != ST_S6);
      out_valid   <= (state_d == ST_S6);
      in_ack      <= (state_q == ST_WAIT_IN) && (state_d == ST_S7);
      // A stop seen mid-sample is held until the sequencer is back at WAIT_IN.
      stop_pend_q <= (state_d != ST_IDLE) && (stop_pend_q || stop);
      case (state_q)
        ST_S7: alloc_idx_q <= '0;
        ST_S1: begin
          tap_len_q    <= tap_len;
          alloc_last_q <= alloc_last;
          err_req_q    <= err_req;
        end
        ST_S2: tap_cnt_q <= tap_len_q;
        ST_S3: tap_cnt_q <= tap_cnt_q - TAPS_W'(1);
        ST_S4: if (idx_at_max && !alloc_last_q) seq_err <= 1'b1;
        ST_S8: alloc_idx_q <= alloc_idx_q + ALLOC_W'(1);
        default: ;
      endcase
    end
  end

`ifdef SRC_SEQ_PERF_CNT_EN
  logic [15:0] perf_q, perf_inc;

  assign perf_inc = (perf_q == 16'hFFFF) ? perf_q : perf_q + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q  <= '0;
      cyc_cnt <= '0;
    end else begin
      if (state_q == ST_WAIT_IN) perf_q <= '0;
      else if (!state_q[3])      perf_q <= perf_inc;
      if (out_valid && out_ready) cyc_cnt <= perf_inc;
    end
  end
`else
  assign cyc_cnt = '0;
`endif

endmodule
